// File: rtl/music_pkg.sv
// Shared types and constants for the music player: FSM states, pitch codes,
// note frequencies and the elaboration-time half-period helper.
package music_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_GAP} seq_state_t;

  localparam logic [4:0] PITCH_REST = 5'd0;
  localparam logic [4:0] PITCH_C4 = 5'd1,  PITCH_D4 = 5'd2,  PITCH_E4 = 5'd3,  PITCH_F4 = 5'd4;
  localparam logic [4:0] PITCH_G4 = 5'd5,  PITCH_A4 = 5'd6,  PITCH_B4 = 5'd7;
  localparam logic [4:0] PITCH_C5 = 5'd8,  PITCH_D5 = 5'd9,  PITCH_E5 = 5'd10, PITCH_F5 = 5'd11;
  localparam logic [4:0] PITCH_G5 = 5'd12, PITCH_A5 = 5'd13, PITCH_B5 = 5'd14;
  localparam logic [4:0] PITCH_C6 = 5'd15, PITCH_D6 = 5'd16, PITCH_E6 = 5'd17, PITCH_F6 = 5'd18;
  localparam logic [4:0] PITCH_G6 = 5'd19, PITCH_A6 = 5'd20, PITCH_B6 = 5'd21;

  // Zero entries mark rest codes (0 and 22..31).
  localparam int unsigned NOTE_HZ [32] = '{
    0,
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988,
    1047, 1175, 1319, 1397, 1568, 1760, 1976,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0
  };

  localparam int PITCH_MSB = 7;
  localparam int PITCH_LSB = 3;
  localparam int BEAT_MSB  = 2;
  localparam int BEAT_LSB  = 0;

  typedef struct packed {
    logic [4:0] pitch;
    logic [2:0] beats;
  } rom_entry_t;

  function automatic logic [31:0] half_period(input int unsigned clk_freq, input logic [4:0] code);
    if (NOTE_HZ[code] == 0) return 32'd0;
    return 32'(clk_freq / (32'd2 * NOTE_HZ[code]));
  endfunction

  function automatic logic is_rest(input logic [4:0] code);
    return (NOTE_HZ[code] == 0);
  endfunction

  function automatic logic [7:0] mk_entry(input logic [4:0] pitch, input logic [2:0] beats);
    logic [7:0] e;
    e = '0;
    e[PITCH_MSB:PITCH_LSB] = pitch;
    e[BEAT_MSB:BEAT_LSB]   = beats;
    return e;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the player top level and the note sequencer.
interface note_sequencer_if #(parameter int SONG_LEN = 32);
  localparam int IDX_W = $clog2(SONG_LEN);

  logic             start;
  logic             stop;
  logic             loop_en;
  logic [31:0]      cnt_max;
  logic             mute;
  logic [IDX_W-1:0] note_idx;
  logic             busy;
  logic             done;

  modport master (output start, stop, loop_en, input cnt_max, mute, note_idx, busy, done);
  modport slave  (input start, stop, loop_en, output cnt_max, mute, note_idx, busy, done);
endinterface

// File: rtl/note_rom.sv
// Song ROM, 256x8, registered read (one-cycle latency).
module note_rom
  import music_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else begin
      case (addr)
        8'd0:    data <= mk_entry(PITCH_A4,   3'd1);
        8'd1:    data <= mk_entry(PITCH_REST, 3'd2);
        8'd2:    data <= mk_entry(PITCH_A4,   3'd1);
        8'd3:    data <= mk_entry(PITCH_A5,   3'd3);
        8'd4:    data <= mk_entry(PITCH_G5,   3'd1);
        8'd5:    data <= mk_entry(PITCH_F5,   3'd1);
        8'd6:    data <= mk_entry(PITCH_E5,   3'd2);
        8'd7:    data <= mk_entry(PITCH_D5,   3'd2);
        8'd8:    data <= mk_entry(PITCH_C5,   3'd4);
        8'd9:    data <= mk_entry(PITCH_REST, 3'd1);
        8'd10:   data <= mk_entry(PITCH_E5,   3'd1);
        8'd11:   data <= mk_entry(PITCH_G5,   3'd1);
        8'd12:   data <= mk_entry(PITCH_C6,   3'd2);
        8'd13:   data <= mk_entry(PITCH_B5,   3'd1);
        8'd14:   data <= mk_entry(PITCH_A5,   3'd1);
        8'd15:   data <= mk_entry(PITCH_G5,   3'd4);
        default: data <= mk_entry(PITCH_REST, 3'd1);
      endcase
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps through the note ROM and drives half-period count and mute for the tone generator.
// Define NOTE_GAP_EN to append GAP_CYCLES of silence after every note.
module note_sequencer
  import music_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 500_000,
  parameter int          SONG_LEN    = 32
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  note_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(SONG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

  if (64'(BEAT_CYCLES) * 64'd7 >= 64'h1_0000_0000 || BEAT_CYCLES == 0) begin : g_beat_chk
    $error("note_sequencer: BEAT_CYCLES must be nonzero and 7*BEAT_CYCLES below 2^32");
  end
  if (SONG_LEN < 2 || SONG_LEN > 256 || GAP_CYCLES == 0) begin : g_len_chk
    $error("note_sequencer: SONG_LEN must be 2..256 and GAP_CYCLES at least 1");
  end

  // Constant per-code table; no divider is built.
  logic [31:0] tone_tab [32];
  for (genvar g = 0; g < 32; g++) begin : g_tab
    assign tone_tab[g] = half_period(CLK_FREQ, 5'(g));
  end

  seq_state_t       state;
  rom_entry_t       rom_q;
  logic [7:0]       rom_data;
  logic [IDX_W-1:0] idx_nxt;
  logic [31:0]      beat_cnt;
  logic [31:0]      beat_load;
  logic [2:0]       beats_eff;
  logic             advance;
  logic             last;
`ifdef NOTE_GAP_EN
  logic [31:0]      gap_cnt;
`endif

  // ROM is addressed with the index being written this edge so its output is valid during LOAD.
  note_rom u_rom (.clk(sys_clk), .rst_n(sys_rst_n), .addr(8'(idx_nxt)), .data(rom_data));
  assign rom_q = rom_entry_t'(rom_data);

  assign beats_eff = (rom_q.beats == 3'd0) ? 3'd1 : rom_q.beats;
  assign beat_load = 32'(beats_eff) * BEAT_CYCLES - 32'd1;
  assign last      = (bus.note_idx == LAST_IDX);

`ifdef NOTE_GAP_EN
  assign advance = (state == ST_GAP) && (gap_cnt == '0);
`else
  assign advance = (state == ST_PLAY) && (beat_cnt == '0);
`endif

  always_comb begin
    idx_nxt = bus.note_idx;
    if (!bus.stop) begin
      if (state == ST_IDLE && bus.start) idx_nxt = '0;
      else if (advance)                  idx_nxt = last ? '0 : bus.note_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      bus.cnt_max  <= '0;
      bus.mute     <= 1'b1;
      bus.note_idx <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      beat_cnt     <= '0;
`ifdef NOTE_GAP_EN
      gap_cnt      <= '0;
`endif
    end else begin
      bus.done     <= 1'b0;
      bus.note_idx <= idx_nxt;
      if (bus.stop) begin
        state       <= ST_IDLE;
        bus.cnt_max <= '0;
        bus.mute    <= 1'b1;
        bus.busy    <= 1'b0;
        beat_cnt    <= '0;
`ifdef NOTE_GAP_EN
        gap_cnt     <= '0;
`endif
      end else if (advance) begin
        bus.cnt_max <= '0;
        bus.mute    <= 1'b1;
        if (last && !bus.loop_en) begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end else begin
          state <= ST_LOAD;
        end
      end else begin
        case (state)
          ST_IDLE: if (bus.start) begin
            state    <= ST_LOAD;
            bus.busy <= 1'b1;
          end
          ST_LOAD: begin
            state       <= ST_PLAY;
            bus.cnt_max <= tone_tab[rom_q.pitch];
            bus.mute    <= is_rest(rom_q.pitch);
            beat_cnt    <= beat_load;
          end
          ST_PLAY: begin
`ifdef NOTE_GAP_EN
            if (beat_cnt == '0) begin
              state       <= ST_GAP;
              bus.cnt_max <= '0;
              bus.mute    <= 1'b1;
              gap_cnt     <= 32'(GAP_CYCLES - 1);
            end else begin
              beat_cnt <= beat_cnt - 32'd1;
            end
`else
            beat_cnt <= beat_cnt - 32'd1;
`endif
          end
`ifdef NOTE_GAP_EN
          ST_GAP:  gap_cnt <= gap_cnt - 32'd1;
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: cycle timeline model built from the song table, plus literal pins.
module tb_note_sequencer;
`ifdef NOTE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int BEAT     = 10;
  localparam int GAP      = 2;
  localparam int LEN      = 4;
  localparam int DONE_CYC = GAP_EN ? 83 : 75;
  localparam int LOOP_CYC = GAP_EN ? 84 : 76;
  localparam int SONG_P [LEN] = '{6, 0, 6, 13};
  localparam int SONG_B [LEN] = '{1, 2, 1, 3};

  typedef struct {
    logic [31:0] cnt;
    logic        mute;
    logic [1:0]  idx;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  note_sequencer_if #(.SONG_LEN(LEN)) bus ();
  note_sequencer #(.CLK_FREQ(50_000_000), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(LEN))
    dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus));

  function automatic exp_t mk(input logic [31:0] c, input logic m, input int i, input logic b, input logic d);
    exp_t e;
    e.cnt = c; e.mute = m; e.idx = 2'(i); e.busy = b; e.done = d;
    return e;
  endfunction

  function automatic logic [31:0] tone_of(input int code);
    case (code)
      6:       return 32'(50_000_000 / (2 * 440));
      13:      return 32'(50_000_000 / (2 * 880));
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Timeline model: one queue element per cycle of the song.
  exp_t q[$];
  exp_t cur = '{cnt: 32'd0, mute: 1'b1, idx: 2'd0, busy: 1'b0, done: 1'b0};
  bit   playing = 1'b0;

  task automatic push_song();
    for (int i = 0; i < LEN; i++) begin
      q.push_back(mk(0, 1'b1, i, 1'b1, 1'b0));
      for (int b = 0; b < SONG_B[i] * BEAT; b++)
        q.push_back(mk(tone_of(SONG_P[i]), (SONG_P[i] == 0), i, 1'b1, 1'b0));
      if (GAP_EN)
        for (int g = 0; g < GAP; g++) q.push_back(mk(0, 1'b1, i, 1'b1, 1'b0));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete(); playing = 1'b0; cur = mk(0, 1'b1, 0, 1'b0, 1'b0);
      end else if (bus.stop) begin
        q.delete(); playing = 1'b0; cur = mk(0, 1'b1, int'(cur.idx), 1'b0, 1'b0);
      end else if (playing) begin
        if (q.size() == 0) begin
          if (bus.loop_en) begin push_song(); cur = q.pop_front(); end
          else begin playing = 1'b0; cur = mk(0, 1'b1, 0, 1'b0, 1'b1); end
        end else cur = q.pop_front();
      end else begin
        cur.done = 1'b0;
        if (bus.start) begin push_song(); playing = 1'b1; cur = q.pop_front(); end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cnt_max",  bus.cnt_max,        cur.cnt);
      chk("mute",     32'(bus.mute),      32'(cur.mute));
      chk("note_idx", 32'(bus.note_idx),  32'(cur.idx));
      chk("busy",     32'(bus.busy),      32'(cur.busy));
      chk("done",     32'(bus.done),      32'(cur.done));
    end
  end

  // Leaves the bench at the negedge inside cycle 1 (LOAD of entry 0).
  task automatic start_song(input logic lp);
    @(negedge clk); bus.loop_en = lp; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    repeat (20) @(negedge clk);
    chk("idle_cnt",  bus.cnt_max, 32'd0);
    chk("idle_mute", 32'(bus.mute), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // single pass, no loop
    start_song(1'b0);
    chk("c1_busy", 32'(bus.busy), 32'd1);
    chk("c1_mute", 32'(bus.mute), 32'd1);
    @(negedge clk);
    chk("c2_cnt",  bus.cnt_max, 32'd56818);
    chk("c2_mute", 32'(bus.mute), 32'd0);
    repeat (10) @(negedge clk);
    chk("c12_cnt", bus.cnt_max, 32'd0);
    chk("c12_idx", 32'(bus.note_idx), GAP_EN ? 32'd0 : 32'd1);
    repeat (48) @(negedge clk);
    chk("c60_cnt", bus.cnt_max, 32'd28409);
    chk("c60_idx", 32'(bus.note_idx), 32'd3);
    repeat (DONE_CYC - 61) @(negedge clk);
    chk("pre_done", 32'(bus.done), 32'd0);
    chk("pre_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy",  32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_clear", 32'(bus.done), 32'd0);

    // looping: entry 0 again after the last entry
    start_song(1'b1);
    repeat (LOOP_CYC - 1) @(negedge clk);
    chk("loop_cnt",  bus.cnt_max, 32'd56818);
    chk("loop_idx",  32'(bus.note_idx), 32'd0);
    chk("loop_busy", 32'(bus.busy), 32'd1);
    repeat (10) @(negedge clk);
    pulse_stop();
    bus.loop_en = 1'b0;
    repeat (5) @(negedge clk);

    // stop during entry 2 PLAY
    start_song(1'b0);
    repeat (39) @(negedge clk);
    chk("c40_idx", 32'(bus.note_idx), 32'd2);
    pulse_stop();
    chk("stop_cnt",  bus.cnt_max, 32'd0);
    chk("stop_mute", 32'(bus.mute), 32'd1);
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_done", 32'(bus.done), 32'd0);
    repeat (5) @(negedge clk);

    // start+stop together, then start while busy
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.stop = 1'b0;
    chk("ss_busy", 32'(bus.busy), 32'd0);
    chk("ss_mute", 32'(bus.mute), 32'd1);
    start_song(1'b0);
    repeat (19) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("restart_busy", 32'(bus.busy), 32'd1);
    chk("restart_idx",  32'(bus.note_idx), 32'd1);
    repeat (DONE_CYC - 19) @(negedge clk);

    // asynchronous reset mid-note
    start_song(1'b0);
    repeat (4) @(negedge clk);
    chk("c5_cnt", bus.cnt_max, 32'd56818);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cnt",  bus.cnt_max, 32'd0);
    chk("arst_mute", 32'(bus.mute), 32'd1);
    chk("arst_idx",  32'(bus.note_idx), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
